seq_divider_128by64: RTL and testbench

Multi-cycle unsigned restoring divider. It is the inverse datapath of the team's 64x64 multiplier: it takes a 2N-bit dividend (e.g. a product) and an N-bit divisor, and returns an N-bit quotient and an N-bit remainder. It retires STEPS quotient bits per clock using a start/ready/done handshake. It sits beside the multiplier in the arithmetic unit and shares its operand widths.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 23 ++
 rtl/seq_divider_128by64.sv | 144 ++++++++++++++
 tb/tb_seq_divider_128by64.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the parameter legality check used at elaboration.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient bits per cycle must be 1, 2 or 4 and divide the operand width.
    function automatic bit steps_legal(input int steps, input int width);
        return ((steps == 1) || (steps == 2) || (steps == 4)) &&
               (width >= 2) && ((width % steps) == 0);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted = {r, q_msb};
        diff    = shifted[WIDTH:0] - {1'b0, d};
        q_bit   = (shifted >= {2'b00, d});
        r_next  = q_bit ? diff : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_divider_128by64.sv
// Multi-cycle unsigned 2N-by-N restoring divider with start/ready/done handshake,
// retiring STEPS quotient bits per clock; flags divide-by-zero and quotient overflow.
module seq_divider_128by64
    import div_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEPS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 ready,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 ovf,
    output logic                 dz
);

    localparam int CNT_MAX = WIDTH / STEPS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_MAX);

    generate
        if (!steps_legal(STEPS, WIDTH)) begin : g_bad_steps
            $error("seq_divider_128by64: STEPS must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    state_t               state_q, state_d;
    logic [WIDTH:0]       r_q, r_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     d_q, d_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 dz_q, dz_d;

    logic [WIDTH-1:0]     div_hi, div_lo;
    logic [STEPS:0][WIDTH:0]   r_chain;
    logic [STEPS:0][WIDTH-1:0] q_chain;

    assign div_hi = dividend[2*WIDTH-1:WIDTH];
    assign div_lo = dividend[WIDTH-1:0];

    // Partial remainder and quotient shift register ripple through STEPS steps per clock.
    assign r_chain[0] = r_q;
    assign q_chain[0] = q_q;

    generate
        for (genvar i = 0; i < STEPS; i++) begin : g_step
            logic q_bit;
            div_step #(.WIDTH(WIDTH)) u_step (
                .r      (r_chain[i]),
                .q_msb  (q_chain[i][WIDTH-1]),
                .d      (d_q),
                .r_next (r_chain[i+1]),
                .q_bit  (q_bit)
            );
            assign q_chain[i+1] = {q_chain[i][WIDTH-2:0], q_bit};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    d_d   = divisor;
                    ovf_d = 1'b0;
                    dz_d  = 1'b0;
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        q_d     = '1;
                        r_d     = {1'b0, div_lo};
                        state_d = DONE;
                    end else if (div_hi >= divisor) begin
                        ovf_d   = 1'b1;
                        q_d     = '1;
                        r_d     = '0;
                        state_d = DONE;
                    end else begin
                        r_d     = {1'b0, div_hi};
                        q_d     = div_lo;
                        cnt_d   = CNT_LOAD;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                r_d   = r_chain[STEPS];
                q_d   = q_chain[STEPS];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    // Divisor is pure data, only meaningful after an accept.
    always_ff @(posedge clk) begin
        d_q <= d_d;
    end

    assign ready     = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign quotient  = q_q;
    assign remainder = r_q[WIDTH-1:0];
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_seq_divider_128by64.sv
// Scoreboard bench for seq_divider_128by64 at STEPS 1, 2 and 4: the driver queues
// expected results and done-cycles, per-instance monitors pop and compare on done.
module tb_seq_divider_128by64;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] r;
        logic        ovf;
        logic        dz;
        logic [31:0] cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] dividend;
    logic [63:0]  divisor;
    logic         st1, st2, st4;
    logic         rdy1, rdy2, rdy4;
    logic         dn1, dn2, dn4;
    logic [63:0]  quo1, quo2, quo4;
    logic [63:0]  rem1, rem2, rem4;
    logic         ov1, ov2, ov4;
    logic         dz1, dz2, dz4;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider_128by64 #(.WIDTH(64), .STEPS(1)) u1 (
        .clk(clk), .rst(rst), .start(st1), .dividend(dividend), .divisor(divisor),
        .ready(rdy1), .done(dn1), .quotient(quo1), .remainder(rem1), .ovf(ov1), .dz(dz1));
    seq_divider_128by64 #(.WIDTH(64), .STEPS(2)) u2 (
        .clk(clk), .rst(rst), .start(st2), .dividend(dividend), .divisor(divisor),
        .ready(rdy2), .done(dn2), .quotient(quo2), .remainder(rem2), .ovf(ov2), .dz(dz2));
    seq_divider_128by64 #(.WIDTH(64), .STEPS(4)) u4 (
        .clk(clk), .rst(rst), .start(st4), .dividend(dividend), .divisor(divisor),
        .ready(rdy4), .done(dn4), .quotient(quo4), .remainder(rem4), .ovf(ov4), .dz(dz4));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic score(input string tag, input bit have, input exp_t e,
                         input logic [63:0] quo, input logic [63:0] rem,
                         input logic ov, input logic dzv);
        chk({tag, " done expected"}, 128'(have), 128'd1);
        if (have) begin
            chk({tag, " quotient"}, 128'(quo), 128'(e.q));
            chk({tag, " remainder"}, 128'(rem), 128'(e.r));
            chk({tag, " ovf/dz"}, 128'({ov, dzv}), 128'({e.ovf, e.dz}));
            chk({tag, " done cycle"}, 128'(cyc), 128'(e.cyc));
        end
    endtask

    // Per-instance monitors: score each done, then confirm results hold into IDLE.
    bit pend1, pend2, pend4, hv1, hv2, hv4;
    exp_t e1, e2, e4;
    logic [127:0] hq1, hq2, hq4;

    always @(negedge clk) begin
        if (rst) pend1 = 1'b0;
        else if (dn1) begin
            hv1 = (q1.size() > 0);
            e1  = hv1 ? q1.pop_front() : '0;
            score("s1", hv1, e1, quo1, rem1, ov1, dz1);
            hq1 = {quo1, rem1}; pend1 = 1'b1;
        end else if (pend1) begin
            pend1 = 1'b0;
            chk("s1 hold", {quo1, rem1}, hq1);
        end
    end

    always @(negedge clk) begin
        if (rst) pend2 = 1'b0;
        else if (dn2) begin
            hv2 = (q2.size() > 0);
            e2  = hv2 ? q2.pop_front() : '0;
            score("s2", hv2, e2, quo2, rem2, ov2, dz2);
            hq2 = {quo2, rem2}; pend2 = 1'b1;
        end else if (pend2) begin
            pend2 = 1'b0;
            chk("s2 hold", {quo2, rem2}, hq2);
        end
    end

    always @(negedge clk) begin
        if (rst) pend4 = 1'b0;
        else if (dn4) begin
            hv4 = (q4.size() > 0);
            e4  = hv4 ? q4.pop_front() : '0;
            score("s4", hv4, e4, quo4, rem4, ov4, dz4);
            hq4 = {quo4, rem4}; pend4 = 1'b1;
        end else if (pend4) begin
            pend4 = 1'b0;
            chk("s4 hold", {quo4, rem4}, hq4);
        end
    end

    function automatic exp_t mk(input logic [63:0] eq, input logic [63:0] er,
                                input bit eo, input bit ez, input int steps, input int c);
        exp_t e;
        e.q   = eq;
        e.r   = er;
        e.ovf = eo;
        e.dz  = ez;
        e.cyc = 32'(c + ((eo || ez) ? 1 : (64 / steps + 1)));
        return e;
    endfunction

    task automatic issue(input bit [2:0] mask, input logic [127:0] dvd, input logic [63:0] dvs,
                         input logic [63:0] eq, input logic [63:0] er, input bit eo, input bit ez);
        int t = 0;
        @(negedge clk);
        while (!((!mask[0] || rdy1) && (!mask[1] || rdy2) && (!mask[2] || rdy4)) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("ready wait", 128'(t < 500), 128'd1);
        dividend = dvd;
        divisor  = dvs;
        st1 = mask[0];
        st2 = mask[1];
        st4 = mask[2];
        if (mask[0]) q1.push_back(mk(eq, er, eo, ez, 1, cyc));
        if (mask[1]) q2.push_back(mk(eq, er, eo, ez, 2, cyc));
        if (mask[2]) q4.push_back(mk(eq, er, eo, ez, 4, cyc));
        @(negedge clk);
        st1 = 1'b0;
        st2 = 1'b0;
        st4 = 1'b0;
    endtask

    task automatic wait_all_idle();
        int t = 0;
        while (!(rdy1 && rdy2 && rdy4 && q1.size() == 0 && q2.size() == 0 && q4.size() == 0)
               && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("idle wait", 128'(t < 3000), 128'd1);
    endtask

    initial begin
        logic [63:0]  rq, rd, rr;
        logic [127:0] dv;
        int           c0;

        rst = 1'b1; st1 = 1'b0; st2 = 1'b0; st4 = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset ready/done", {rdy1, dn1, rdy2, dn2, rdy4, dn4}, 6'b101010);
        chk("reset s1 outputs", {quo1, rem1, ov1, dz1}, '0);
        chk("reset s4 outputs", {quo4, rem4, ov4, dz4}, '0);
        rst = 1'b0;

        issue(3'b111, {64'd1, 64'd0}, 64'd3, 64'h5555555555555555, 64'd1, 1'b0, 1'b0);
        issue(3'b111, 128'hFFFFFFFFFFFFFFFE_0000000000000001, 64'hFFFFFFFFFFFFFFFF,
              64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0, 1'b0);
        issue(3'b111, 128'h1234, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'h1234, 1'b0, 1'b1);
        issue(3'b111, {64'd5, 64'd7}, 64'd5, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 1'b0);
        issue(3'b111, {64'hDEAD, 64'hBEEF}, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'hBEEF, 1'b0, 1'b1);
        issue(3'b111, 128'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0);
        issue(3'b111, 128'd0, 64'd1, 64'd0, 64'd0, 1'b0, 1'b0);
        issue(3'b111, {64'd1, 64'd0}, 64'd2, 64'h8000000000000000, 64'd0, 1'b0, 1'b0);
        issue(3'b111, {64'd4, 64'd0}, 64'd5, 64'hCCCCCCCCCCCCCCCC, 64'd4, 1'b0, 1'b0);
        issue(3'b111, {64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFF}, 64'hFFFFFFFFFFFFFFFF,
              64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0);

        // Operands built as q*d + r with r < d, so quotient and remainder are known exactly.
        for (int i = 0; i < 10; i++) begin
            rd = (i % 2 == 1) ? 64'($urandom_range(1, 15)) : ({$urandom, $urandom} | 64'h1);
            rq = {$urandom, $urandom};
            rr = {$urandom, $urandom} % rd;
            dv = {64'd0, rq} * {64'd0, rd} + {64'd0, rr};
            issue(3'b111, dv, rd, rq, rr, 1'b0, 1'b0);
        end
        wait_all_idle();

        // start pulsed mid-RUN must not disturb the in-flight division.
        issue(3'b001, 128'd1000, 64'd9, 64'd111, 64'd1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        dividend = 128'd77;
        divisor  = 64'd3;
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        wait_all_idle();

        // start held high on STEPS=4: second accept on the first IDLE cycle after DONE.
        @(negedge clk);
        c0 = cyc;
        dividend = 128'd100;
        divisor  = 64'd7;
        st4 = 1'b1;
        q4.push_back(mk(64'd14, 64'd2, 1'b0, 1'b0, 4, c0));
        q4.push_back(mk(64'd14, 64'd2, 1'b0, 1'b0, 4, c0 + 18));
        repeat (20) @(negedge clk);
        st4 = 1'b0;
        wait_all_idle();

        // Reset during RUN aborts silently; no expectation is queued for it.
        @(negedge clk);
        dividend = {64'd1, 64'd0};
        divisor  = 64'd3;
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort in RUN", 128'(rdy1), 128'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort ready/done", {rdy1, dn1}, 2'b10);
        chk("abort outputs", {quo1, rem1, ov1, dz1}, '0);
        repeat (80) @(negedge clk);

        wait_all_idle();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got cycle %0d want completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
